// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a valid/ready request side and a valid/ready
// result side. Every operation except MUL completes in one cycle. MUL is a
// shift-add multiplier that handles one multiplier bit per cycle.
// Build option: define ALU_MUL_EN to build the multiplier and the BUSY state.
// Without it, opcode 111 completes in one cycle with Result=0, zero=1, err=1.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no result held; a request is accepted whenever in_valid=1
// BUSY  | shift-add multiply in progress (built only with ALU_MUL_EN)
// DONE  | Result/flags/err hold a completed operation (out_valid=1)
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       flags,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DONE = 2'd2;
`ifdef ALU_MUL_EN
  localparam logic [1:0] BUSY = 2'd1;
  localparam int CNT_W = $clog2(WIDTH + 1);
`endif

  // WIDTH always fits in WIDTH bits for the legal range 4..64
  localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

  logic [1:0]       state;
  logic             accept;
  logic             start_mul;
  logic             shamt_big;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   dif_ext;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_err;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign shamt_big = (B >= W_LIM);

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mcand;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     part;

  assign start_mul = accept && (opcode == OP_MUL);
  // upper half of the product plus the multiplicand when the current multiplier bit is set
  assign part = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

  // shift-add datapath: prod holds {partial sum, remaining multiplier bits}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod  <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else if (start_mul) begin
      prod  <= {{WIDTH{1'b0}}, B};
      mcand <= A;
      cnt   <= CNT_W'(WIDTH);
    end else if ((state == BUSY) && (cnt != '0)) begin
      prod <= {part, prod[WIDTH-1:1]};
      cnt  <= cnt - CNT_W'(1);
    end
  end
`else
  assign start_mul = 1'b0;
`endif

  // single-cycle result and carry/overflow for everything but MUL
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    sum_ext = {1'b0, A} + {1'b0, B};
    dif_ext = {1'b0, A} - {1'b0, B};
    shl_ext = {1'b0, A} << B;
    case (opcode)
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif_ext[WIDTH-1:0];
        alu_c   = dif_ext[WIDTH];
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (dif_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_SHL: begin
        if (!shamt_big) begin
          alu_res = shl_ext[WIDTH-1:0];
          alu_c   = shl_ext[WIDTH];
        end
      end
      OP_SHR: begin
        if (!shamt_big) alu_res = A >> B;
      end
      OP_MUL: begin
`ifndef ALU_MUL_EN
        alu_err = 1'b1;
`endif
      end
    endcase
  end

  // FSM and result registers; accepting in DONE retires the old result on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      Result <= '0;
      flags  <= '0;
      err    <= 1'b0;
    end else if (accept && !start_mul) begin
      state  <= DONE;
      Result <= alu_res;
      flags  <= {alu_res[WIDTH-1], ~|alu_res, alu_c, alu_v};
      err    <= alu_err;
`ifdef ALU_MUL_EN
    end else if (start_mul) begin
      state <= BUSY;
    end else if ((state == BUSY) && (cnt == '0)) begin
      state  <= DONE;
      Result <= prod[WIDTH-1:0];
      flags  <= {prod[WIDTH-1], ~|prod[WIDTH-1:0], |prod[2*WIDTH-1:WIDTH], 1'b0};
      err    <= 1'b0;
`endif
    end else if ((state == DONE) && out_ready) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=16. MUL cases are exercised when the
// bundle is built with ALU_MUL_EN; otherwise opcode 111 is checked as an error.
module tb_alu_mc;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  opcode;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        err;
  logic        out_valid;
  logic        out_ready;

  int n_vec = 0;
  int n_err = 0;

  alu_mc #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .A         (a_in),
    .B         (b_in),
    .Result    (result),
    .flags     (flags),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // present a request at the falling edge, return 1 ns after the accepting edge
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = op;
    a_in     = a;
    b_in     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] res, input logic [3:0] flg, input logic e);
    string tag;
    tag = $sformatf("op%0d_%h_%h", op, a, b);
    issue(op, a, b);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_res"}, result, res);
    check({tag, "_flags"}, flags, flg);
    check({tag, "_err"}, err, e);
  endtask

  task automatic go_idle();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

`ifdef ALU_MUL_EN
  task automatic mul_case(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] res, input logic [3:0] flg);
    int lat;
    int busy_rdy;
    bit got;
    lat = 0;
    busy_rdy = 0;
    got = 1'b0;
    issue(3'b111, a, b);
    check("mul_busy_valid", out_valid, 1'b0);
    check("mul_busy_ready", in_ready, 1'b0);
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        got = 1'b1;
        lat = c;
      end else if (in_ready) begin
        busy_rdy++;
      end
    end
    check("mul_latency", lat, 17);
    check("mul_ready_while_busy", busy_rdy, 0);
    check("mul_res", result, res);
    check("mul_flags", flags, flg);
    check("mul_err", err, 1'b0);
  endtask
`endif

  initial begin
    int stale;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opcode    = 3'b000;
    a_in      = '0;
    b_in      = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_res", result, 16'h0000);
    check("rst_flags", flags, 4'h0);
    check("rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", in_ready, 1'b1);

    // flags = {negative, zero, carry, overflow}
    run_vec(3'b000, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1'b0);
    run_vec(3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b0);
    run_vec(3'b000, 16'h1234, 16'h4321, 16'h5555, 4'b0000, 1'b0);
    run_vec(3'b001, 16'h0003, 16'h0004, 16'hFFFF, 4'b1010, 1'b0);
    run_vec(3'b001, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1'b0);
    run_vec(3'b010, 16'hF0F0, 16'hFF00, 16'hF000, 4'b1000, 1'b0);
    run_vec(3'b011, 16'h0F0F, 16'hF000, 16'hFF0F, 4'b1000, 1'b0);
    run_vec(3'b100, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100, 1'b0);
    run_vec(3'b101, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 1'b0);
    run_vec(3'b101, 16'h00F0, 16'h0004, 16'h0F00, 4'b0000, 1'b0);
    run_vec(3'b101, 16'h1000, 16'h0004, 16'h0000, 4'b0110, 1'b0);
    run_vec(3'b101, 16'h8000, 16'h0000, 16'h8000, 4'b1000, 1'b0);
    run_vec(3'b101, 16'h0001, 16'h0010, 16'h0000, 4'b0100, 1'b0);
    run_vec(3'b110, 16'h00FF, 16'h0010, 16'h0000, 4'b0100, 1'b0);
    run_vec(3'b110, 16'h8000, 16'h000F, 16'h0001, 4'b0000, 1'b0);

`ifdef ALU_MUL_EN
    mul_case(16'd200, 16'd61, 16'h2FA8, 4'b0000);
    mul_case(16'h0100, 16'h0100, 16'h0000, 4'b0110);
`else
    run_vec(3'b111, 16'h0005, 16'h0003, 16'h0000, 4'b0100, 1'b1);
`endif

    // result handshake: DONE drains to IDLE when out_ready=1 and nothing is offered
    go_idle();
    check("drain_valid", out_valid, 1'b0);
    check("drain_ready", in_ready, 1'b1);

    // hold an AND result under backpressure while a request is offered and must be ignored
    out_ready = 1'b0;
    issue(3'b010, 16'hF0F0, 16'hFF00);
    in_valid = 1'b1;
    opcode   = 3'b000;
    a_in     = 16'h0001;
    b_in     = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_valid", i), out_valid, 1'b1);
      check($sformatf("hold%0d_res", i), result, 16'hF000);
      check($sformatf("hold%0d_flags", i), flags, 4'b1000);
      check($sformatf("hold%0d_ready", i), in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    opcode    = 3'b100;
    a_in      = 16'hF000;
    b_in      = 16'hF000;
    #1;
    check("b2b_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b_valid", out_valid, 1'b1);
    check("b2b_res", result, 16'h0000);
    check("b2b_flags", flags, 4'b0100);

    // reset in the middle of an operation aborts it with no stale result afterwards
    go_idle();
`ifdef ALU_MUL_EN
    issue(3'b111, 16'd200, 16'd61);
    repeat (7) @(posedge clk);
    #2;
`else
    out_ready = 1'b0;
    issue(3'b010, 16'hF0F0, 16'hFF00);
    repeat (2) @(posedge clk);
    #2;
`endif
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 1'b0);
    check("abort_res", result, 16'h0000);
    check("abort_flags", flags, 4'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    check("abort_stale", stale, 0);
    check("abort_ready", in_ready, 1'b1);
    run_vec(3'b000, 16'h0002, 16'h0003, 16'h0005, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand and result width in bits (legal 4..64).
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port in_valid  input  1  operation request valid.
REQ-005 Port in_ready  output  1  block can accept a request this cycle.
REQ-006 Port opcode  input  3  operation select, sampled on acceptance.
REQ-007 Port A  input  WIDTH  first operand, sampled on acceptance.
REQ-008 Port B  input  WIDTH  second operand, sampled on acceptance.
REQ-009 Port Result  output  WIDTH  registered result, valid while out_valid=1.
REQ-010 Port flags  output  4  {negative, zero, carry, overflow}, qualified by out_valid.
REQ-011 Port err  output  1  unsupported opcode, qualified by out_valid.
REQ-012 Port out_valid  output  1  Result/flags/err hold a completed operation.
REQ-013 Port out_ready  input  1  consumer takes the result this cycle.

Function
REQ-014 Opcodes SHALL be 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SHL (A<<B), 110 SHR logical (A>>B), 111 MUL (low WIDTH bits of A*B, unsigned).
REQ-015 A request SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, otherwise 0.
REQ-016 FSM states SHALL be IDLE, BUSY, DONE: IDLE/DONE->DONE on accepting a non-MUL op; IDLE/DONE->BUSY on accepting MUL; BUSY->DONE after WIDTH iteration cycles; DONE->IDLE when out_ready=1 and nothing accepted; DONE holds otherwise.
REQ-017 Non-MUL latency SHALL be 1 cycle (out_valid=1 the cycle after acceptance); MUL latency SHALL be WIDTH+1 cycles, via shift-add, one multiplier bit per cycle.
REQ-018 out_valid SHALL be 1 exactly in DONE; Result, flags and err SHALL remain stable while out_valid=1 and out_ready=0.
REQ-019 Simultaneous out_ready=1 and acceptance in DONE SHALL retire the old result and load the new op in the same edge (back-to-back, no bubble for non-MUL ops).
REQ-020 in_valid, opcode, A, B SHALL be ignored while in_ready=0.
REQ-021 zero = (Result==0); negative = Result[WIDTH-1].
REQ-022 carry SHALL be: ADD carry-out; SUB borrow (1 when A<B unsigned); SHL last bit shifted out (0 if B=0); MUL 1 when the upper WIDTH bits of the full product are nonzero; logic ops and SHR 0.
REQ-023 overflow SHALL be two's-complement signed overflow for ADD/SUB, 0 for all other opcodes.
REQ-024 For SHL/SHR with B>=WIDTH, Result SHALL be 0 and carry 0.
REQ-025 err SHALL be 0 for every opcode except as stated in Configuration.

Reset
REQ-026 While rst_n=0 the FSM SHALL be IDLE, Result=0, flags=0, err=0, out_valid=0; in_ready SHALL read 1 once rst_n=1.
REQ-027 Reset asserted in BUSY or DONE SHALL abort the operation immediately; no result is produced after release.

Configuration
REQ-028 With macro ALU_MUL_EN defined, opcode 111 SHALL perform MUL as specified.
REQ-029 Without ALU_MUL_EN, no multiplier logic or BUSY state SHALL be built; opcode 111 SHALL complete in 1 cycle with Result=0, flags={0,1,0,0}, err=1.

Verification (WIDTH=16)
REQ-030 ADD A=0xFFFF B=0x0001 -> Result=0x0000, zero=1, carry=1, overflow=0, out_valid one cycle after acceptance.
REQ-031 ADD A=0x7FFF B=0x0001 -> Result=0x8000, negative=1, overflow=1; SUB A=3 B=4 -> Result=0xFFFF, carry=1, negative=1.
REQ-032 MUL A=200 B=61 (ALU_MUL_EN) -> Result=0x2FA8, carry=0, out_valid exactly 17 cycles after acceptance, in_ready=0 meanwhile; MUL 0x0100*0x0100 -> Result=0, zero=1, carry=1.
REQ-033 SHL A=0x8001 B=1 -> Result=0x0002, carry=1; SHR A=0x00FF B=16 -> Result=0, zero=1.
REQ-034 Hold out_ready=0 for 5 cycles after an AND result -> Result/flags stable, in_ready=0; then out_ready=1 with in_valid=1 XOR -> XOR accepted same edge, out_valid stays 1 with new result next cycle.
REQ-035 Assert rst_n=0 mid-MUL (cycle 8) -> out_valid=0, Result=0 immediately; after release no stale result appears and a new ADD completes normally.
